// File: rtl/tile_fetch.sv
// Scanline tile fetcher: ROM address generator, returned-word buffer and 4bpp serialiser.
// Latency: line_start to first pix_valid is 3 cycles; one pixel/cycle after that; a stalled pix_ready stops fetching.
module tile_fetch #(
  parameter int LINE_PIXELS = 256,
  parameter int FIFO_WORDS  = 2
) (
  input  logic        clk_draw,
  input  logic        rst_draw_n,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  input  logic [7:0]  scroll_x,
  output logic [13:0] tile_addr,
  input  logic [15:0] tile_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [3:0]  pix_data,
  output logic        pix_last,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_WORDS);
  localparam int CW = PW + 1;
  localparam int SW = PW + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [13:0]   addr_q, addr_d;
  logic [7:0]    row_q, row_d;
  logic [5:0]    word_x_q, word_x_d;
  logic [6:0]    words_left_q, words_left_d;
  logic          p1_q, p1_d, p2_q, p2_d;
  logic [1:0]    idx_q, idx_d;
  logic [8:0]    pix_cnt_q, pix_cnt_d;
  logic [15:0]   mem_q [FIFO_WORDS];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [9:0]    span;
  logic [6:0]    words_init;
  logic [SW-1:0] occ;
  logic [15:0]   head;
  logic          hs, last_hs, flush, push, pop, issue;

  // Words covering LINE_PIXELS pixels that start scroll_x[1:0] nibbles into the first word.
  assign span       = 10'(LINE_PIXELS) + {8'd0, scroll_x[1:0]} + 10'd3;
  assign words_init = span[8:2];

  // p1: address on the ROM bus, p2: data on tile_data this cycle.
  assign occ   = SW'(cnt_q) + SW'(p1_q) + SW'(p2_q);
  assign head  = mem_q[rd_ptr_q];

  assign busy      = (state_q == RUN);
  assign pix_valid = busy && (cnt_q != '0);
  assign pix_last  = pix_valid && (pix_cnt_q == 9'(LINE_PIXELS - 1));
  assign tile_addr = addr_q;

  assign hs      = pix_valid & pix_ready;
  assign last_hs = hs & pix_last;
  // Leftover nibbles of the final word are dropped when the line completes.
  assign flush   = line_start | last_hs;
  assign push    = p2_q & ~flush;
  assign pop     = hs & (idx_q == 2'd3) & ~flush;
  assign issue   = busy && !line_start && (words_left_q != 7'd0) && (occ < SW'(FIFO_WORDS));

  always_comb begin
    pix_data = 4'd0;
    if (pix_valid) begin
      case (idx_q)
        2'd0:    pix_data = head[15:12];
        2'd1:    pix_data = head[11:8];
        2'd2:    pix_data = head[7:4];
        default: pix_data = head[3:0];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_d        = row_q;
    word_x_d     = word_x_q;
    words_left_d = words_left_q;
    p1_d         = 1'b0;
    p2_d         = line_start ? 1'b0 : p1_q;
    idx_d        = idx_q;
    pix_cnt_d    = pix_cnt_q;

    if (line_start) begin
      state_d = RUN;
    end else if (last_hs) begin
      state_d = IDLE;
    end

    if (line_start) begin
      addr_d       = {line_y, scroll_x[7:2]};
      row_d        = line_y;
      word_x_d     = scroll_x[7:2] + 6'd1;
      words_left_d = words_init - 7'd1;
      p1_d         = 1'b1;
      idx_d        = scroll_x[1:0];
      pix_cnt_d    = 9'd0;
    end else begin
      if (issue) begin
        addr_d       = {row_q, word_x_q};
        word_x_d     = word_x_q + 6'd1;
        words_left_d = words_left_q - 7'd1;
        p1_d         = 1'b1;
      end
      if (hs) begin
        idx_d     = idx_q + 2'd1;
        pix_cnt_d = pix_cnt_q + 9'd1;
      end
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      row_q        <= '0;
      word_x_q     <= '0;
      words_left_q <= '0;
      p1_q         <= 1'b0;
      p2_q         <= 1'b0;
      idx_q        <= '0;
      pix_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_q        <= row_d;
      word_x_q     <= word_x_d;
      words_left_q <= words_left_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      idx_q        <= idx_d;
      pix_cnt_q    <= pix_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk_draw) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tile_data;
    end
  end

endmodule

// File: tb/tb_tile_fetch.sv
// Directed bench for tile_fetch: ROM model, pixel scoreboard keyed on source coordinates.
module tb_tile_fetch;

  logic        clk_draw   = 1'b0;
  logic        rst_draw_n = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  line_y     = 8'd0;
  logic [7:0]  scroll_x   = 8'd0;
  logic [13:0] tile_addr;
  logic [15:0] tile_data  = 16'd0;
  logic        pix_valid;
  logic        pix_ready  = 1'b0;
  logic [3:0]  pix_data;
  logic        pix_last;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [4:0]  exp_q[$];
  logic [13:0] alog[$];
  int cyc = 0, start_cyc = 0, last_cyc = -1, acc = 0, vld_cnt = 0;
  bit first_pending = 0, done = 0, hold = 0, abort_chk = 0;
  logic [3:0]  hold_dat;
  logic        hold_last;
  logic [13:0] saved_addr;
  int s0;

  function automatic logic [15:0] rom_f(input logic [13:0] a);
    return {a[5:0], a[13:8], a[7:4]} ^ 16'h5A3C;
  endfunction

  tile_fetch dut (
    .clk_draw   (clk_draw),
    .rst_draw_n (rst_draw_n),
    .line_start (line_start),
    .line_y     (line_y),
    .scroll_x   (scroll_x),
    .tile_addr  (tile_addr),
    .tile_data  (tile_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .busy       (busy)
  );

  always #5 clk_draw = ~clk_draw;

  always @(posedge clk_draw) tile_data <= rom_f(tile_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [7:0] y, input logic [7:0] sx);
    logic [7:0]  x;
    logic [15:0] w;
    logic [3:0]  n;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      x = sx + 8'(i);
      w = rom_f({y, x[7:2]});
      case (x[1:0])
        2'd0:    n = w[15:12];
        2'd1:    n = w[11:8];
        2'd2:    n = w[7:4];
        default: n = w[3:0];
      endcase
      exp_q.push_back({(i == 255), n});
    end
  endtask

  // One clock: drive inputs at the falling edge, then score what the DUT shows this cycle.
  task automatic step(input logic ls, input logic [7:0] y, input logic [7:0] sx,
                      input logic rdy, input bit ls_at_last);
    logic [4:0] e;
    logic       h;
    @(negedge clk_draw);
    cyc++;
    if (ls_at_last && pix_valid && pix_last) ls = 1'b1;
    line_start = ls;
    line_y     = y;
    scroll_x   = sx;
    pix_ready  = rdy;
    if (abort_chk) begin
      check("valid_after_start", pix_valid, 0);
      abort_chk = 0;
    end
    if (hold) begin
      check("hold_valid", pix_valid, 1);
      check("hold_data", pix_data, hold_dat);
      check("hold_last", pix_last, hold_last);
    end
    hold      = pix_valid && !rdy && !ls;
    hold_dat  = pix_data;
    hold_last = pix_last;
    if (pix_valid) vld_cnt++;
    if (first_pending && pix_valid) begin
      check("first_valid_cycle", cyc - start_cyc, 3);
      first_pending = 0;
    end
    if ((cyc - start_cyc >= 1) && (alog.size() == 0 || tile_addr != alog[$]))
      alog.push_back(tile_addr);
    h = pix_valid && rdy;
    if (h) begin
      check("pixel_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_data", pix_data, e[3:0]);
        check("pix_last", pix_last, e[4]);
        acc++;
        if (e[4]) begin
          done     = 1;
          last_cyc = cyc;
        end
      end
    end
    if (ls) begin
      push_line(y, sx);
      start_cyc     = cyc;
      first_pending = 1;
      abort_chk     = 1;
      done          = 0;
      acc           = 0;
      hold          = 0;
      alog.delete();
    end
  endtask

  task automatic finish_line(input bit rnd);
    for (int k = 0; k < 4000 && !done; k++)
      step(1'b0, 8'd0, 8'd0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 0);
    check("line_done", done, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_draw);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_last", pix_last, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", tile_addr, 14'h0000);
    rst_draw_n = 1'b1;
    step(0, 8'd0, 8'd0, 1, 0);

    // Line 1: no scroll, ready held high.
    step(1, 8'h00, 8'h00, 1, 0);
    step(0, 8'd0, 8'd0, 1, 0);
    check("busy_run", busy, 1);
    check("first_addr", tile_addr, 14'h0000);
    finish_line(0);
    check("last_cycle", last_cyc - start_cyc, 258);
    check("pixels_accepted", acc, 256);
    check("addr_count", alog.size(), 64);
    for (int i = 0; i < alog.size(); i++) check("addr_seq", alog[i], i);
    step(0, 8'd0, 8'd0, 1, 0);
    check("busy_idle", busy, 0);
    check("valid_idle", pix_valid, 0);

    // Line 2: scroll with wrap across word 63 -> 0.
    step(1, 8'h2B, 8'h06, 1, 0);
    step(0, 8'd0, 8'd0, 1, 0);
    check("scroll_first_addr", tile_addr, 14'h0AC1);
    finish_line(0);
    check("scroll_addr_count", alog.size(), 65);
    check("scroll_addr0", alog[0], 14'h0AC1);
    check("scroll_addr63", alog[63], 14'h0AC0);
    check("scroll_addr64", alog[64], 14'h0AC1);

    // Line 3: random backpressure.
    step(1, 8'h47, 8'hC3, 1'($urandom_range(0, 1)), 0);
    finish_line(1);

    // Line 4: consumer stalled for 20 cycles right after line_start.
    step(1, 8'h81, 8'h11, 0, 0);
    repeat (19) step(0, 8'd0, 8'd0, 0, 0);
    check("stalled_fetches", alog.size() <= 3, 1);
    saved_addr = tile_addr;
    step(0, 8'd0, 8'd0, 0, 0);
    check("stalled_addr_hold", tile_addr, saved_addr);
    finish_line(0);

    // Line 5 ends in the same cycle the next line starts.
    step(1, 8'h33, 8'h01, 1, 0);
    s0 = start_cyc;
    for (int k = 0; k < 4000 && start_cyc == s0; k++) step(0, 8'h34, 8'h02, 1, 1);
    check("seam_same_cycle", last_cyc, start_cyc);
    step(0, 8'd0, 8'd0, 1, 0);
    check("seam_busy", busy, 1);
    finish_line(0);

    // Line 7 aborted at pixel 100 by a new line.
    step(1, 8'h05, 8'h02, 1, 0);
    for (int k = 0; k < 400 && acc < 100; k++) step(0, 8'd0, 8'd0, 1, 0);
    check("abort_reached", acc, 100);
    step(1, 8'h10, 8'h00, 1, 0);
    finish_line(0);

    // Reset in the middle of a line.
    step(1, 8'h22, 8'h09, 1, 0);
    for (int k = 0; k < 2000 && acc < 50; k++) step(0, 8'd0, 8'd0, 1'($urandom_range(0, 1)), 0);
    #2 rst_draw_n = 1'b0;
    #1;
    check("midrst_valid", pix_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_last", pix_last, 0);
    check("midrst_data", pix_data, 0);
    check("midrst_addr", tile_addr, 14'h0000);
    exp_q.delete();
    first_pending = 0;
    hold          = 0;
    abort_chk     = 0;
    #1 rst_draw_n = 1'b1;
    vld_cnt = 0;
    repeat (20) step(0, 8'd0, 8'd0, 1, 0);
    check("valid_after_reset", vld_cnt, 0);
    check("busy_after_reset", busy, 0);

    step(1, 8'hFF, 8'hFF, 1, 0);
    finish_line(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
